// File: rtl/pipelined_adder_if.sv
// Handshake/data bundle for pipelined_adder: operand side (in_*) and result side (out_*, s, flags).
// master drives operands and out_ready; slave is the adder itself.
interface pipelined_adder_if #(
  parameter int WIDTH = 106
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             zero;

  modport master (
    output in_valid, in_a, in_b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, zero
  );

  modport slave (
    input  in_valid, in_a, in_b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, zero
  );
endinterface

// File: rtl/pipelined_adder.sv
// Segmented, pipelined add/subtract: stage k adds operand segment k with the carry registered by
// stage k-1, carrying the finished low sum bits and the not-yet-used operand bits along with the beat.
module pipelined_adder #(
  parameter int WIDTH  = 106,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);
  localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [WIDTH:0]   wide_t;

  typedef struct packed {
    logic  valid;
    word_t a;      // operand A, only bits at/above the current segment still matter
    word_t b;      // effective operand B (already inverted for subtract)
    word_t sum;    // result bits of all segments finished so far
    logic  carry;  // carry into the next segment
  } stage_t;

  stage_t [STAGES-1:0] stage_q;
  stage_t [STAGES-1:0] stage_d;
  stage_t [STAGES-1:0] prev;    // what each stage loads from: the input beat or stage k-1

  logic  adv;
  int    lo;
  int    seg_w;
  wide_t mask;
  wide_t a_seg;
  wide_t b_seg;
  wide_t sum_w;

  // The whole pipe moves as one; it only freezes when a finished result is being refused.
  assign adv = !stage_q[STAGES-1].valid || bus.out_ready;

  always_comb begin
    prev          = '0;
    prev[0].valid = bus.in_valid;
    prev[0].a     = bus.in_a;
    prev[0].b     = bus.in_b ^ {WIDTH{bus.sub}};
    prev[0].sum   = '0;
    prev[0].carry = bus.c_in ^ bus.sub;
    for (int k = 1; k < STAGES; k++) begin
      prev[k] = stage_q[k-1];
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a value on every path (here: hold) so no latch is inferred.
    stage_d = stage_q;
    lo      = 0;
    seg_w   = 0;
    mask    = '0;
    a_seg   = '0;
    b_seg   = '0;
    sum_w   = '0;
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        // Segments past the top of the word are empty and simply pass the carry through.
        lo    = (k * SEG < WIDTH) ? k * SEG : WIDTH;
        seg_w = (lo + SEG < WIDTH) ? SEG : WIDTH - lo;
        mask  = (wide_t'(1) << seg_w) - wide_t'(1);
        a_seg = (wide_t'(prev[k].a) >> lo) & mask;
        b_seg = (wide_t'(prev[k].b) >> lo) & mask;
        sum_w = a_seg + b_seg + wide_t'(prev[k].carry);

        stage_d[k].valid = prev[k].valid;
        stage_d[k].a     = prev[k].a;
        stage_d[k].b     = prev[k].b;
        stage_d[k].sum   = prev[k].sum | word_t'((sum_w & mask) << lo);
        stage_d[k].carry = |(sum_w >> seg_w);
      end
    end
  end

  // NOTE: data and carry registers are reset along with the valid bits so s/c_out read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      stage_q <= stage_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = stage_q[STAGES-1].valid;
  assign bus.s         = stage_q[STAGES-1].sum;
  assign bus.c_out     = stage_q[STAGES-1].carry;
  assign bus.zero      = (stage_q[STAGES-1].sum == '0);
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (106/4, 13/4, 13/1) checked every cycle against a
// beat-level scoreboard, plus directed literal cases, stall, and mid-flight reset on the wide one.
module tb_pipelined_adder;
  logic clk;
  logic rst_n0;
  logic rst_n1;

  pipelined_adder_if #(.WIDTH(106)) if0 ();
  pipelined_adder_if #(.WIDTH(13))  if1 ();
  pipelined_adder_if #(.WIDTH(13))  if2 ();

  pipelined_adder #(.WIDTH(106), .STAGES(4)) u_dut0 (.clk(clk), .rst_n(rst_n0), .bus(if0.slave));
  pipelined_adder #(.WIDTH(13),  .STAGES(4)) u_dut1 (.clk(clk), .rst_n(rst_n1), .bus(if1.slave));
  pipelined_adder #(.WIDTH(13),  .STAGES(1)) u_dut2 (.clk(clk), .rst_n(rst_n1), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [106:0] model_res(input logic [105:0] a, input logic [105:0] b,
                                             input logic c, input logic sb, input int w);
    logic [107:0] m;
    logic [107:0] full;
    logic         co;
    m = (108'(1) << w) - 108'(1);
    if (!sb) begin
      full = 108'(a) + 108'(b) + 108'(c);
      co   = ((full >> w) & 108'(1)) != 108'(0);
    end else begin
      full = 108'(a) - 108'(b) - 108'(c);
      co   = 108'(a) >= (108'(b) + 108'(c));
    end
    return {co, 106'(full & m)};
  endfunction

  function automatic logic [105:0] rand106();
    return 106'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Scoreboard: each accepted beat remembers the advance count at acceptance; it is presented
  // once the pipe has advanced STAGES-1 more times.
  typedef struct packed {
    logic [105:0] s;
    logic         c_out;
    logic [31:0]  stamp;
  } exp_t;

  exp_t        sb_mem [3][8];
  int unsigned head [3];
  int unsigned tail [3];
  int unsigned adv_cnt [3];
  int unsigned pushes [3];
  int          st_of [3] = '{4, 4, 1};
  int          wd_of [3] = '{106, 13, 13};

  logic         g_rst [3];
  logic         g_iv [3];
  logic         g_ir [3];
  logic         g_ov [3];
  logic         g_or [3];
  logic         g_c [3];
  logic         g_sub [3];
  logic         g_cout [3];
  logic         g_zero [3];
  logic [105:0] g_a [3];
  logic [105:0] g_b [3];
  logic [105:0] g_s [3];
  exp_t         m_front;
  logic         m_ev;
  logic         m_adv;
  logic [106:0] m_res;

  initial begin
    for (int d = 0; d < 3; d++) begin
      head[d] = 0; tail[d] = 0; adv_cnt[d] = 0; pushes[d] = 0;
    end
    forever begin
      @(negedge clk);
      g_rst[0] = rst_n0;        g_rst[1] = rst_n1;        g_rst[2] = rst_n1;
      g_iv[0]  = if0.in_valid;  g_iv[1]  = if1.in_valid;  g_iv[2]  = if2.in_valid;
      g_ir[0]  = if0.in_ready;  g_ir[1]  = if1.in_ready;  g_ir[2]  = if2.in_ready;
      g_ov[0]  = if0.out_valid; g_ov[1]  = if1.out_valid; g_ov[2]  = if2.out_valid;
      g_or[0]  = if0.out_ready; g_or[1]  = if1.out_ready; g_or[2]  = if2.out_ready;
      g_c[0]   = if0.c_in;      g_c[1]   = if1.c_in;      g_c[2]   = if2.c_in;
      g_sub[0] = if0.sub;       g_sub[1] = if1.sub;       g_sub[2] = if2.sub;
      g_cout[0]= if0.c_out;     g_cout[1]= if1.c_out;     g_cout[2]= if2.c_out;
      g_zero[0]= if0.zero;      g_zero[1]= if1.zero;      g_zero[2]= if2.zero;
      g_a[0] = if0.in_a; g_a[1] = 106'(if1.in_a); g_a[2] = 106'(if2.in_a);
      g_b[0] = if0.in_b; g_b[1] = 106'(if1.in_b); g_b[2] = 106'(if2.in_b);
      g_s[0] = if0.s;    g_s[1] = 106'(if1.s);    g_s[2] = 106'(if2.s);
      for (int d = 0; d < 3; d++) begin
        m_front = sb_mem[d][head[d] % 8];
        m_ev    = (head[d] != tail[d]) && ((adv_cnt[d] - m_front.stamp) == 32'(st_of[d] - 1));
        if (!g_rst[d]) begin
          check($sformatf("dut%0d out_valid in reset", d), 128'(g_ov[d]), 128'(0));
          head[d] = tail[d];
        end else begin
          check($sformatf("dut%0d out_valid", d), 128'(g_ov[d]), 128'(m_ev));
          check($sformatf("dut%0d in_ready", d), 128'(g_ir[d]), 128'(!m_ev || g_or[d]));
          if (m_ev && g_ov[d]) begin
            check($sformatf("dut%0d s", d), 128'(g_s[d]), 128'(m_front.s));
            check($sformatf("dut%0d c_out", d), 128'(g_cout[d]), 128'(m_front.c_out));
            check($sformatf("dut%0d zero", d), 128'(g_zero[d]), 128'(m_front.s == '0));
          end
          m_adv = !m_ev || g_or[d];
          if (m_adv) begin
            adv_cnt[d]++;
            if (m_ev) head[d]++;
            if (g_iv[d]) begin
              m_res = model_res(g_a[d], g_b[d], g_c[d], g_sub[d], wd_of[d]);
              sb_mem[d][tail[d] % 8] = '{s: m_res[105:0], c_out: m_res[106], stamp: adv_cnt[d]};
              tail[d]++;
              pushes[d]++;
            end
          end
        end
      end
    end
  end

  // One isolated beat on the wide unit; result and latency against hand-computed literals.
  task automatic send_one(input logic [105:0] a, input logic [105:0] b, input logic c,
                          input logic sb, input logic [105:0] es, input logic ec, input string name);
    int lat;
    if0.in_valid  = 1'b1;
    if0.in_a      = a;
    if0.in_b      = b;
    if0.c_in      = c;
    if0.sub       = sb;
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    lat = 1;
    while (!if0.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 128'(lat), 128'(4));
    check({name, " s"}, 128'(if0.s), 128'(es));
    check({name, " c_out"}, 128'(if0.c_out), 128'(ec));
    check({name, " zero"}, 128'(if0.zero), 128'(es == '0));
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n, input int stall_at, input int stall_len,
                        output int hs, output int max_run);
    int   sent;
    int   run;
    logic acc;
    logic need_new;
    sent = 0; run = 0; hs = 0; max_run = 0; need_new = 1'b1;
    for (int cyc = 0; cyc < n + stall_len + 12; cyc++) begin
      if0.in_valid = (sent < n);
      if (need_new) begin
        if0.in_a = rand106();
        if0.in_b = rand106();
        if0.c_in = 1'($urandom);
        if0.sub  = 1'($urandom);
        need_new = 1'b0;
      end
      if0.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      acc = if0.in_valid && if0.in_ready;
      if (if0.out_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (if0.out_valid && if0.out_ready) hs++;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        need_new = 1'b1;
      end
    end
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b1;
  endtask

  task automatic main_seq();
    int hs;
    int max_run;
    send_one('1, 106'd1, 1'b0, 1'b0, 106'd0, 1'b1, "carry_ripple");
    send_one(106'd5, 106'd7, 1'b0, 1'b1, ~106'd1, 1'b0, "sub_borrow");
    send_one(106'd7, 106'd5, 1'b1, 1'b1, 106'd1, 1'b1, "sub_borrow_in");
    send_one(106'd9, 106'd9, 1'b0, 1'b1, 106'd0, 1'b1, "sub_equal");
    send_one(106'd3, 106'd4, 1'b1, 1'b0, 106'd8, 1'b0, "add_small");

    stream(8, 100, 0, hs, max_run);
    check("burst beats out", 128'(hs), 128'(8));
    check("burst consecutive out_valid", 128'(max_run), 128'(8));
    stream(8, 5, 3, hs, max_run);
    check("stall beats out", 128'(hs), 128'(8));

    for (int i = 0; i < 300; i++) begin
      if0.in_valid  = ($urandom_range(0, 3) != 0);
      if0.in_a      = ($urandom_range(0, 7) == 0) ? '1 : rand106();
      if0.in_b      = ($urandom_range(0, 7) == 0) ? if0.in_a : rand106();
      if0.c_in      = 1'($urandom);
      if0.sub       = 1'($urandom);
      if0.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      if0.in_valid = 1'b1;
      if0.in_a     = 106'(5 + i);
      if0.in_b     = 106'd6;
      if0.c_in     = 1'b0;
      if0.sub      = 1'b0;
      @(posedge clk); #1;
    end
    if0.in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre-reset out_valid", 128'(if0.out_valid), 128'(1));
    check("pre-reset s", 128'(if0.s), 128'(11));
    rst_n0 = 1'b0;
    #1;
    check("async reset out_valid", 128'(if0.out_valid), 128'(0));
    check("async reset s", 128'(if0.s), 128'(0));
    check("async reset c_out", 128'(if0.c_out), 128'(0));
    check("async reset zero", 128'(if0.zero), 128'(1));
    @(posedge clk); #1;
    rst_n0 = 1'b1;
    #1;
    check("in_ready after reset", 128'(if0.in_ready), 128'(1));
    send_one(106'd1, 106'd1, 1'b0, 1'b0, 106'd2, 1'b0, "post_reset");
  endtask

  task automatic small_seq();
    int cyc;
    cyc = 0;
    while ((pushes[1] < 10000 || pushes[2] < 10000) && cyc < 40000) begin
      if1.in_valid  = ($urandom_range(0, 4) != 0);
      if1.in_a      = ($urandom_range(0, 7) == 0) ? 13'h1fff : 13'($urandom);
      if1.in_b      = 13'($urandom);
      if1.c_in      = 1'($urandom);
      if1.sub       = 1'($urandom);
      if1.out_ready = ($urandom_range(0, 4) != 0);
      if2.in_valid  = ($urandom_range(0, 4) != 0);
      if2.in_a      = 13'($urandom);
      if2.in_b      = ($urandom_range(0, 7) == 0) ? if2.in_a : 13'($urandom);
      if2.c_in      = 1'($urandom);
      if2.sub       = 1'($urandom);
      if2.out_ready = ($urandom_range(0, 4) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.out_ready = 1'b1;
    check("13/4 beat count reached", 128'(pushes[1] >= 10000), 128'(1));
    check("13/1 beat count reached", 128'(pushes[2] >= 10000), 128'(1));
  endtask

  initial begin
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.c_in = 1'b0; if0.sub = 1'b0;
    if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.c_in = 1'b0; if1.sub = 1'b0;
    if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_a = '0; if2.in_b = '0; if2.c_in = 1'b0; if2.sub = 1'b0;
    if2.out_ready = 1'b1;
    #1;
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 128'(if0.out_valid), 128'(0));
    check("reset s", 128'(if0.s), 128'(0));
    check("reset c_out", 128'(if0.c_out), 128'(0));
    check("reset zero", 128'(if0.zero), 128'(1));
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    #1;
    check("reset release in_ready", 128'(if0.in_ready), 128'(1));
    @(posedge clk); #1;

    fork
      main_seq();
      small_seq();
    join

    repeat (8) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d drained", d), 128'(tail[d] - head[d]), 128'(0));
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
